// File: rtl/ipsl_hmic_h_ddrphy_dll_update_sched.sv
// ipsl_hmic_h_ddrphy_dll_update_sched: merges periodic and software DLL update requests and runs the ctrl/DLL req-ack sequence
//   rclk, rst                       clock, synchronous active-high reset
//   periodic_en, sw_update_req      request sources (timer enable, 1-cycle pulse)
//   ctrl_upd_req / ctrl_upd_ack     traffic-free window handshake with the memory controller
//   dll_update_req / dll_update_ack training handshake with the DLL update controller
//   busy, update_cnt, timeout_err   status; err_clr clears timeout_err
module ipsl_hmic_h_ddrphy_dll_update_sched #(
    parameter int                  TIMER_W     = 20,
    parameter logic [TIMER_W-1:0]  INTERVAL    = 20'd500000,
    parameter int                  ACK_TO_W    = 10,
    parameter logic [ACK_TO_W-1:0] ACK_TIMEOUT = 10'd1000
) (
    input  logic       rclk,
    input  logic       rst,
    input  logic       periodic_en,
    input  logic       sw_update_req,
    output logic       ctrl_upd_req,
    input  logic       ctrl_upd_ack,
    output logic       dll_update_req,
    input  logic       dll_update_ack,
    output logic       busy,
    output logic [7:0] update_cnt,
    output logic       timeout_err,
    input  logic       err_clr
);
    typedef enum logic [2:0] {IDLE, CTRL_REQ, DLL_REQ, DLL_REL, CTRL_REL} state_t;
    localparam logic [TIMER_W-1:0]  TIMER_LAST = INTERVAL - 1'b1;
    localparam logic [ACK_TO_W-1:0] WAIT_LAST  = ACK_TIMEOUT - 1'b1;
    state_t state, state_nx;
    logic pend_sw, pend_per, timed_out, start, ack_to, done, tick;
    logic [TIMER_W-1:0] timer;
    logic [ACK_TO_W-1:0] wait_cnt;
    assign start  = state == IDLE && (pend_sw || pend_per);
    assign ack_to = state == CTRL_REQ && !ctrl_upd_ack && wait_cnt == WAIT_LAST;
    assign done   = state == CTRL_REL && !ctrl_upd_ack;
    assign tick   = periodic_en && state == IDLE && !pend_per && timer == TIMER_LAST;
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     state_nx = start ? CTRL_REQ : IDLE;
            CTRL_REQ: state_nx = ctrl_upd_ack ? DLL_REQ : ack_to ? CTRL_REL : CTRL_REQ;
            DLL_REQ:  state_nx = dll_update_ack ? DLL_REL : DLL_REQ;
            DLL_REL:  state_nx = dll_update_ack ? DLL_REL : CTRL_REL;
            CTRL_REL: state_nx = ctrl_upd_ack ? CTRL_REL : IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge rclk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // Starting a sequence consumes both pending flags so coalesced requests run once.
    always_ff @(posedge rclk) begin
        if (rst) begin
            pend_sw     <= 1'b0;
            pend_per    <= 1'b0;
            timed_out   <= 1'b0;
            timer       <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            update_cnt  <= '0;
        end else begin
            pend_sw     <= start ? 1'b0 : pend_sw | sw_update_req;
            pend_per    <= start ? 1'b0 : pend_per | tick;
            timed_out   <= start ? 1'b0 : timed_out | ack_to;
            timer       <= (!periodic_en || done || tick) ? '0 :
                           (state == IDLE && !pend_per) ? timer + 1'b1 : timer;
            wait_cnt    <= state == CTRL_REQ ? wait_cnt + 1'b1 : '0;
            timeout_err <= ack_to | (timeout_err & ~err_clr);
            if (done && !timed_out && update_cnt != 8'hff) update_cnt <= update_cnt + 8'd1;
        end
    end
    assign ctrl_upd_req   = state == CTRL_REQ || state == DLL_REQ || state == DLL_REL;
    assign dll_update_req = state == DLL_REQ;
    assign busy           = state != IDLE;
endmodule
